// File: rtl/mul_8x8_apprx_seq.sv
// Sequential 8x8 approximate multiplier: one 4x4 approximate cell reused over four nibble pairs.
// Optional ZERO_SKIP_EN: zero operands bypass the step sequence and complete immediately.

module mul_2x2_apprx (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [2:0] p_o
);
  // 3x3 is reported as 7 so the product fits in three bits.
  assign p_o = (a_i == 2'd3 && b_i == 2'd3) ? 3'd7 : ({1'b0, a_i} * {1'b0, b_i});
endmodule

module mul_4x4_apprx (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0][2:0] pp;

  for (genvar g = 0; g < 4; g++) begin : g_cell
    mul_2x2_apprx u_cell (
      .a_i (a_i[2*(g%2) +: 2]),
      .b_i (b_i[2*(g/2) +: 2]),
      .p_o (pp[g])
    );
  end

  assign p_o = {5'b0, pp[0]} + ({5'b0, pp[1]} << 2) + ({5'b0, pp[2]} << 2) + ({5'b0, pp[3]} << 4);
endmodule

module mul_8x8_apprx_seq #(
  parameter int PP_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, STEP, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d, p_q, p_d;
  logic [7:0]  pp_q, pp_d;
  logic [3:0]  sh_q, sh_d;
  logic        in_ready_q, in_ready_d;

  logic [3:0]  cell_a, cell_b, sh_c;
  logic [7:0]  pp_c;
  logic [15:0] addend;

  // k[0] selects the high nibble of A, k[1] the high nibble of B.
  assign cell_a = k_q[0] ? a_q[7:4] : a_q[3:0];
  assign cell_b = k_q[1] ? b_q[7:4] : b_q[3:0];
  assign sh_c   = {k_q[0] & k_q[1], k_q[0] ^ k_q[1], 2'b00};

  mul_4x4_apprx u_cell (
    .a_i (cell_a),
    .b_i (cell_b),
    .p_o (pp_c)
  );

  assign addend = (PP_REG != 0) ? ({8'h00, pp_q} << sh_q) : ({8'h00, pp_c} << sh_c);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    pp_d       = pp_q;
    sh_d       = sh_q;
    p_d        = p_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          k_d     = '0;
          pp_d    = '0;
          sh_d    = '0;
          state_d = STEP;
`ifdef ZERO_SKIP_EN
          if (A == 8'h00 || B == 8'h00) begin
            state_d = DONE;
            p_d     = '0;
          end
`endif
        end
      end
      STEP: begin
        // With PP_REG the first step adds the cleared pp_q, i.e. nothing.
        acc_d = acc_q + addend;
        pp_d  = pp_c;
        sh_d  = sh_c;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (PP_REG != 0) begin
            state_d = DRAIN;
          end else begin
            state_d = DONE;
            p_d     = acc_d;
          end
        end
      end
      DRAIN: begin
        acc_d   = acc_q + addend;
        state_d = DONE;
        p_d     = acc_d;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      pp_q       <= '0;
      sh_q       <= '0;
      p_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      pp_q       <= pp_d;
      sh_q       <= sh_d;
      p_q        <= p_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign P         = p_q;
endmodule
